alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational 64-bit add/sub/xor/and ALU among NREQ requesters (execute stage, address generation, etc.).
//  Round-robin arbitration with valid/ready on each request port, a 2-stage operand/result pipeline, and one response port with backpressure.
//  Each response carries the result, the Y86 condition codes (ZF, SF, OF) and the ID of the requester that issued it.
// PARAMETERS
//  NREQ    2   number of requesters, 2..8
//  DATA_W  64  operand/result width; ID width IDW = max(1,$clog2(NREQ)) is a derived localparam
// PORTS
//  clk         in   1             clock; all state updates on rising edge
//  rst         in   1             synchronous reset, active-high
//  req_valid   in   NREQ          request i present
//  req_ready   out  NREQ          one-hot grant; transfer when req_valid[i] & req_ready[i]
//  req_op      in   2*NREQ        op of requester i at [2i+1:2i]: 00 add, 01 sub, 10 xor, 11 and
//  req_a       in   DATA_W*NREQ   operand A of requester i
//  req_b       in   DATA_W*NREQ   operand B of requester i
//  rsp_valid   out  1             response present
//  rsp_ready   in   1             consumer accepts response
//  rsp_id      out  IDW           index of originating requester
//  rsp_result  out  DATA_W        ALU result
//  rsp_zf      out  1             result == 0
//  rsp_sf      out  1             result[DATA_W-1]
//  rsp_of      out  1             signed overflow (0 for xor/and)
//  busy        out  1             S1 or S2 occupied
// BEHAVIOUR
//  Reset: S1/S2 valid = 0; rsp_valid = 0; rsp_id/result/flags = 0; busy = 0; req_ready = 0; RR pointer = NREQ-1 (req 0 highest priority).
//  Pipeline:
//   - S1 holds op/a/b/id; the ALU is driven from S1 registers.
//   - S2 registers the ALU result, flags and id.
//   - S2 drives the rsp_* outputs directly from flops.
//   - s2_free = !S2.v | rsp_ready; s1_adv = S1.v & s2_free; s1_free = !S1.v | s1_adv.
//  Arbitration (combinational):
//   - When s1_free, grant the first i with req_valid[i], searching from ptr+1 upward with wrap-around.
//   - req_ready is one-hot or zero; it is zero whenever !s1_free.
//   - On a transfer, ptr <= granted index and S1 loads that request.
//  Latency and throughput:
//   - Accept at edge N -> rsp_valid high after edge N+1, i.e. 2 cycles.
//   - Throughput is 1 per cycle while rsp_ready = 1.
//  Handshake:
//   - Requesters hold valid/op/a/b stable until granted.
//   - rsp_* stay stable while rsp_valid & !rsp_ready.
//   - Within one cycle, drain S2, advance S1->S2 and accept new->S1 may all occur together.
//  Arithmetic is modulo 2^DATA_W.
//   - add: r = a + b; of = (a[msb] == b[msb]) & (r[msb] != a[msb]).
//   - sub: r = a - b; of = (a[msb] != b[msb]) & (r[msb] != a[msb]); b = 0 never overflows.
//   - xor / and: bitwise; of = 0.
//   - zf and sf follow the result for every op.
//  Boundary conditions:
//   - Full (S1 and S2 valid, rsp_ready = 0): req_ready = 0, nothing moves.
//   - Empty: busy = 0, rsp_valid = 0.
//   - Single requester asserting: granted every cycle it is free, no bubbles.
//   - Pointer wrap-around: after granting NREQ-1, search restarts at 0.
//   - Reset mid-operation: in-flight S1/S2 contents are discarded with no response; ptr returns to NREQ-1.
// TESTING
//  1. add 0x7FFF_FFFF_FFFF_FFFF + 1 from req0 -> 2 cycles later rsp_result = 0x8000_0000_0000_0000, of=1, sf=1, zf=0, id=0.
//  2. sub 5 - 5 from req1 -> result 0, zf=1, sf=0, of=0, id=1; also sub 0x8000...0 - 0 -> of=0.
//  3. Both requesters valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one response per cycle, ids alternating.
//  4. rsp_ready=0 for 5 cycles with both valid -> exactly 2 accepted, then req_ready=0; rsp_* held stable; on release, drain resumes in order.
//  5. xor 0xF0F0.. ^ 0xFFFF.. -> 0x0F0F..; and with 0 -> 0, zf=1, of=0.
//  6. Assert rst with S1 and S2 full -> next cycle rsp_valid=0, busy=0, req0 granted first when both request.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for the shared ALU arbiter.
// The master side is the requesters plus the response consumer.
// The slave side is the arbiter itself.
interface alu_share_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 64
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Request side, one slot per requester
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [2*NREQ-1:0]      req_op;
  logic [DATA_W*NREQ-1:0] req_a;
  logic [DATA_W*NREQ-1:0] req_b;

  // Response side, single port
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [DATA_W-1:0]      rsp_result;
  logic                   rsp_zf;
  logic                   rsp_sf;
  logic                   rsp_of;

  // Pipeline occupancy
  logic                   busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zf, rsp_sf, rsp_of, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shared 64-bit add/sub/xor/and ALU with round-robin arbitration.
// S1 holds the granted request; the ALU sits between S1 and S2.
// S2 holds the result, Y86 flags (ZF/SF/OF) and requester id, and
// drives the response port directly from flops.
module alu_share_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);

  localparam int             IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zf;
    logic              sf;
    logic              of;
  } alu_res_t;

  // Combinational ALU: result modulo 2^DATA_W plus condition codes.
  function automatic alu_res_t alu_eval(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    alu_res_t res;
    logic     msb_a;
    logic     msb_b;
    logic     msb_r;
    res = '0;
    case (op)
      OP_ADD:  res.result = a + b;
      OP_SUB:  res.result = a - b;
      OP_XOR:  res.result = a ^ b;
      OP_AND:  res.result = a & b;
      default: res.result = '0;
    endcase
    msb_a = a[DATA_W-1];
    msb_b = b[DATA_W-1];
    msb_r = res.result[DATA_W-1];
    // Overflow only exists for the arithmetic ops; a - 0 never flags
    // because the result sign always equals the sign of a.
    case (op)
      OP_ADD:  res.of = (msb_a == msb_b) && (msb_r != msb_a);
      OP_SUB:  res.of = (msb_a != msb_b) && (msb_r != msb_a);
      default: res.of = 1'b0;
    endcase
    res.zf = (res.result == {DATA_W{1'b0}});
    res.sf = msb_r;
    return res;
  endfunction

  // Pipeline state
  logic              s1_v_q;
  logic [1:0]        s1_op_q;
  logic [DATA_W-1:0] s1_a_q;
  logic [DATA_W-1:0] s1_b_q;
  logic [IDW-1:0]    s1_id_q;
  logic              s2_v_q;
  alu_res_t          s2_res_q;
  logic [IDW-1:0]    s2_id_q;
  logic [IDW-1:0]    ptr_q;

  // Flow control and arbitration
  logic              s2_free_s;
  logic              s1_adv_s;
  logic              s1_free_s;
  logic [NREQ-1:0]   grant_d;
  logic              grant_hit_d;
  logic [IDW-1:0]    grant_idx_d;
  logic [IDW-1:0]    cand_s;
  logic [1:0]        op_sel_d;
  logic [DATA_W-1:0] a_sel_d;
  logic [DATA_W-1:0] b_sel_d;
  alu_res_t          alu_s;

  // Stage-advance conditions: each stage frees up when its content moves on.
  always_comb begin
    s2_free_s = !s2_v_q || bus.rsp_ready;
    s1_adv_s  = s1_v_q && s2_free_s;
    s1_free_s = !s1_v_q || s1_adv_s;
  end

  // Round-robin search starting one past the last grant, with wrap-around.
  always_comb begin
    grant_d     = '0;
    grant_hit_d = 1'b0;
    grant_idx_d = '0;
    cand_s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDW'((int'(ptr_q) + k) % NREQ);
      if (!rst && s1_free_s && !grant_hit_d && bus.req_valid[cand_s]) begin
        grant_hit_d         = 1'b1;
        grant_idx_d         = cand_s;
        grant_d[cand_s]     = 1'b1;
      end else begin
        grant_hit_d = grant_hit_d;
      end
    end
  end

  // Operand mux selecting the granted requester's op and operands.
  always_comb begin
    op_sel_d = 2'b00;
    a_sel_d  = '0;
    b_sel_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_d[i]) begin
        op_sel_d = bus.req_op[2*i +: 2];
        a_sel_d  = bus.req_a[DATA_W*i +: DATA_W];
        b_sel_d  = bus.req_b[DATA_W*i +: DATA_W];
      end else begin
        op_sel_d = op_sel_d;
      end
    end
  end

  // ALU is fed straight from the S1 registers.
  always_comb begin
    alu_s = alu_eval(s1_op_q, s1_a_q, s1_b_q);
  end

  // Pipeline registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_op_q  <= 2'b00;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_res_q <= '0;
      s2_id_q  <= '0;
      ptr_q    <= PTR_RST;
    end else begin
      // S1: load on a grant, otherwise empty out when its content advances.
      if (grant_hit_d) begin
        s1_v_q  <= 1'b1;
        s1_op_q <= op_sel_d;
        s1_a_q  <= a_sel_d;
        s1_b_q  <= b_sel_d;
        s1_id_q <= grant_idx_d;
        ptr_q   <= grant_idx_d;
      end else if (s1_adv_s) begin
        s1_v_q <= 1'b0;
      end else begin
        s1_v_q <= s1_v_q;
      end
      // S2: hold while the consumer stalls a valid response.
      if (s2_free_s) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_res_q <= alu_s;
          s2_id_q  <= s1_id_q;
        end else begin
          s2_res_q <= s2_res_q;
        end
      end else begin
        s2_v_q <= s2_v_q;
      end
    end
  end

  assign bus.req_ready  = grant_d;
  assign bus.rsp_valid  = s2_v_q;
  assign bus.rsp_id     = s2_id_q;
  assign bus.rsp_result = s2_res_q.result;
  assign bus.rsp_zf     = s2_res_q.zf;
  assign bus.rsp_sf     = s2_res_q.sf;
  assign bus.rsp_of     = s2_res_q.of;
  assign bus.busy       = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (NREQ=2, DATA_W=64).
module tb_alu_share_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  alu_share_arbiter_if #(.NREQ(2), .DATA_W(64)) bus ();

  alu_share_arbiter #(.NREQ(2), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        zf;
    logic        sf;
    logic        of;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int i, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.req_op[2*i +: 2] = op;
    bus.req_a[64*i +: 64] = a;
    bus.req_b[64*i +: 64] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int         acc;
    logic [1:0] exp_g;
    logic [63:0] held;

    clk    = 1'b0;
    rst    = 1'b1;
    n_cmp  = 0;
    n_fail = 0;
    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    vecs[0] = '{0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1, 2'b01, 64'h5, 64'h5, 64'h0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{0, 2'b01, 64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1, 2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1, 2'b01, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{0, 2'b01, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{0, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1, 2'b11, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0, 1'b1, 1'b0};

    // Reset state, with requests already pending
    bus.req_valid = 2'b11;
    tick();
    tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_rsp_result", bus.rsp_result, 64'h0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'h0);
    bus.req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // Table-driven single transactions
    for (int n = 0; n < NV; n++) begin
      bus.req_valid = 2'b00;
      drive_req(vecs[n].req, vecs[n].op, vecs[n].a, vecs[n].b);
      bus.req_valid[vecs[n].req] = 1'b1;
      bus.rsp_ready = 1'b1;
      #1;
      exp_g = 2'b00;
      exp_g[vecs[n].req] = 1'b1;
      chk("vec_grant", 64'(bus.req_ready), 64'(exp_g));
      tick();
      bus.req_valid = 2'b00;
      chk("vec_latency_valid", 64'(bus.rsp_valid), 64'h0);
      chk("vec_busy", 64'(bus.busy), 64'h1);
      tick();
      chk("vec_rsp_valid", 64'(bus.rsp_valid), 64'h1);
      chk("vec_result", bus.rsp_result, vecs[n].r);
      chk("vec_zf", 64'(bus.rsp_zf), 64'(vecs[n].zf));
      chk("vec_sf", 64'(bus.rsp_sf), 64'(vecs[n].sf));
      chk("vec_of", 64'(bus.rsp_of), 64'(vecs[n].of));
      chk("vec_id", 64'(bus.rsp_id), 64'(vecs[n].req));
      tick();
      chk("vec_empty_valid", 64'(bus.rsp_valid), 64'h0);
      chk("vec_empty_busy", 64'(bus.busy), 64'h0);
    end

    // Alternating grants, one response per cycle: req0 add 1+2=3, req1 xor 6^3=5
    do_reset();
    drive_req(0, 2'b00, 64'h1, 64'h2);
    drive_req(1, 2'b10, 64'h6, 64'h3);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_grant", 64'(bus.req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      if (c >= 1) begin
        chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("rr_rsp_id", 64'(bus.rsp_id), 64'((c - 1) % 2));
        chk("rr_result", bus.rsp_result, ((c - 1) % 2 == 0) ? 64'h3 : 64'h5);
      end
    end
    bus.req_valid = 2'b00;
    tick();
    tick();

    // Backpressure: 5 stalled cycles accept exactly two, response held stable
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if ((bus.req_valid & bus.req_ready) != 2'b00) acc++;
      tick();
      if (c >= 2) begin
        chk("bp_hold_valid", 64'(bus.rsp_valid), 64'h1);
        chk("bp_hold_id", 64'(bus.rsp_id), 64'h0);
        chk("bp_hold_result", bus.rsp_result, 64'h3);
      end
    end
    chk("bp_accept_count", 64'(acc), 64'h2);
    chk("bp_full_ready", 64'(bus.req_ready), 64'h0);
    held = bus.rsp_result;
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(bus.req_ready), 64'h1);
    tick();
    chk("bp_drain1_id", 64'(bus.rsp_id), 64'h1);
    chk("bp_drain1_result", bus.rsp_result, 64'h5);
    tick();
    chk("bp_drain2_id", 64'(bus.rsp_id), 64'h0);
    chk("bp_drain2_result", bus.rsp_result, held);
    bus.req_valid = 2'b00;
    tick();
    tick();

    // Single requester: granted every cycle, no bubbles
    do_reset();
    drive_req(1, 2'b00, 64'h10, 64'h20);
    bus.req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("single_grant", 64'(bus.req_ready), 64'h2);
      tick();
      if (c >= 1) begin
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        chk("single_result", bus.rsp_result, 64'h30);
      end
    end
    bus.req_valid = 2'b00;
    tick();
    tick();

    // Reset mid-operation: fill both stages, then discard
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    tick();
    tick();
    chk("midrst_full_busy", 64'(bus.busy), 64'h1);
    chk("midrst_full_valid", 64'(bus.rsp_valid), 64'h1);
    rst = 1'b1;
    tick();
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("midrst_busy", 64'(bus.busy), 64'h0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("midrst_first_grant", 64'(bus.req_ready), 64'h1);
    tick();
    chk("midrst_no_stale", 64'(bus.rsp_valid), 64'h0);
    bus.req_valid = 2'b00;
    tick();
    chk("midrst_new_id", 64'(bus.rsp_id), 64'h0);
    chk("midrst_new_result", bus.rsp_result, 64'h3);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
